bounce_motion_engine: RTL
=========================

// Module: bounce_motion_engine
// PURPOSE
//  Parametrised multi-object motion engine for the bouncing-sprite display project.
//  Holds position and velocity for NUM_OBJ sprites.
//  On each frame_tick it sweeps all objects, one object per cycle, applying velocity
//  with either edge reflection (bounce) or wrap-around.
//  Sits between the VGA timing generator (source of frame_tick) and the sprite renderer
//  (consumer of pos_*_o). The config port lets the top level place and launch objects.
// PARAMETERS
//  NUM_OBJ   4    number of objects, >=1
//  X_W       10   x position width, unsigned
//  Y_W       10   y position width, unsigned
//  VEL_W     4    velocity width, two's complement
//  SCREEN_W  640  visible width in pixels
//  SCREEN_H  480  visible height in pixels
//  OBJ_SIZE  16   sprite edge length; MAX_X=SCREEN_W-OBJ_SIZE, MAX_Y=SCREEN_H-OBJ_SIZE
// PORTS
//  clk            in   1               system clock
//  rst            in   1               synchronous reset, active high
//  frame_tick     in   1               one-cycle pulse per video frame
//  mode_wrap      in   1               0 = bounce at edges, 1 = wrap around; sampled at sweep start
//  freeze         in   1               1 = ignore frame_tick (motion paused)
//  cfg_valid      in   1               config request
//  cfg_ready      out  1               config accept; transfer occurs when valid&&ready
//  cfg_idx        in   clog2(NUM_OBJ)  target object
//  cfg_x, cfg_y   in   X_W, Y_W        new position; clamped to MAX_X / MAX_Y
//  cfg_vx, cfg_vy in   VEL_W           new velocity, signed
//  pos_x_o        out  NUM_OBJ*X_W     packed x positions, object i at [i*X_W +: X_W]
//  pos_y_o        out  NUM_OBJ*Y_W     packed y positions
//  bounce_x_o     out  NUM_OBJ         per-object x-edge hit; pulses with update_done_o
//  bounce_y_o     out  NUM_OBJ         per-object y-edge hit; pulses with update_done_o
//  busy_o         out  1               sweep in progress
//  update_done_o  out  1               one-cycle pulse; sweep complete
//  overrun_o      out  1               sticky: a tick arrived while one was already pending
// BEHAVIOUR
//  Reset state:
//   - all x,y = 0; all vx,vy = +1
//   - busy_o, update_done_o, bounce_*_o, overrun_o, pending = 0
//   - FSM = IDLE; cfg_ready = 1
//  Reset asserted mid-sweep aborts the sweep and returns to reset state on the same edge.
//  FSM states IDLE -> SWEEP -> DONE -> IDLE:
//   - IDLE: moves to SWEEP when (frame_tick || pending) && !freeze && no cfg transfer this cycle.
//   - SWEEP: updates object idx = 0..NUM_OBJ-1, one per cycle; moves to DONE after the last object.
//   - DONE: pulses update_done_o and bounce_*_o for one cycle, then returns to IDLE.
//   - Latency from tick to update_done_o = NUM_OBJ+2 cycles.
//  Tick handling:
//   - frame_tick while busy or during a same-cycle cfg transfer sets pending.
//   - Tick with pending already set: sets overrun_o; the tick is dropped.
//   - Tick while freeze=1: dropped; pending is unchanged.
//  Config port:
//   - cfg_ready = (state==IDLE).
//   - cfg transfer and a start condition in the same cycle: cfg wins, tick is pended.
//   - Written values are visible on pos_*_o the next cycle.
//   - cfg_vx or cfg_vy equal to -2^(VEL_W-1) is stored as -(2^(VEL_W-1)-1), so negation never overflows.
//  Per-axis step (x shown; y identical with MAX_Y):
//   - n = x + sext(vx), computed signed at X_W+2 bits.
//   - bounce mode:
//     - n<0      -> x=0,     vx=-vx, bounce flag set
//     - n>MAX_X  -> x=MAX_X, vx=-vx, bounce flag set
//     - otherwise x=n
//   - wrap mode:
//     - n<0      -> x=n+MAX_X+1
//     - n>MAX_X  -> x=n-(MAX_X+1)
//     - velocity unchanged; no bounce flag
//   - vx=0: position is held; no flag.
//  bounce_*_o flags are collected during SWEEP and cleared at sweep start.
//  pos_*_o always reflect the register contents; consumers sample them after update_done_o.
// STRUCTURE
//  Package bounce_pkg:
//   - state enum {IDLE, SWEEP, DONE}
//   - function clamp_vel
//   - localparams MAX_X, MAX_Y, computed from parameters
//  Sub-module bounce_axis_step (combinational, parametrised on width and max):
//   - inputs pos, vel, wrap; outputs next_pos, next_vel, hit
//   - instantiated twice (x axis, y axis)
//  Top level holds the register arrays, FSM, pending/overrun logic and the object-index counter.
// TESTING
//  1 Reset, then idle: all pos 0, busy_o 0, cfg_ready 1; one tick -> all pos (1,1) at update_done_o,
//    which arrives 6 cycles after the tick.
//  2 cfg obj2 x=622 vx=+3, bounce mode, tick -> obj2 x=624 vx=-3, bounce_x_o=4'b0100 for one cycle;
//    next tick -> x=621.
//  3 mode_wrap=1: obj0 x=622 vx=+3 -> x=0; obj1 x=1 vx=-3 -> x=623; bounce_x_o stays 0.
//  4 Tick, then a tick 2 cycles later (busy) -> second sweep starts the cycle after the first DONE;
//    a third tick during the first sweep -> overrun_o=1 and stays set until reset.
//  5 cfg vx=-8 (VEL_W=4) -> stored -7; freeze=1 with ticks -> no sweep, positions unchanged,
//    cfg still accepted.
//  6 rst=1 on the 2nd SWEEP cycle -> next cycle busy_o=0, all pos 0, update_done_o never pulses.

Source files
------------

// File: rtl/bounce_pkg.sv
// Shared types and helpers for the bouncing-sprite motion engine.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a tick; config port open
// SWEEP | updating one object per cycle, index 0..NUM_OBJ-1
// DONE  | sweep finished; completion and edge-hit flags registered out
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_OBJ_SIZE = 16;

  // Largest legal top-left coordinate so the sprite stays fully on screen.
  function automatic int calc_max(input int screen, input int size);
    return screen - size;
  endfunction

  localparam int MAX_X = calc_max(DEF_SCREEN_W, DEF_OBJ_SIZE);
  localparam int MAX_Y = calc_max(DEF_SCREEN_H, DEF_OBJ_SIZE);

  // Map the most negative w-bit value one step toward zero so that a later
  // reflection (-v) always fits in w bits.
  function automatic logic signed [15:0] clamp_vel(input logic signed [15:0] v, input int w);
    logic signed [15:0] most_neg;
    most_neg = 16'(-(1 <<< (w - 1)));
    if (v == most_neg) return most_neg + 16'sd1;
    return v;
  endfunction

endpackage

// File: rtl/bounce_axis_step.sv
// One-axis position step: applies a signed velocity to an unsigned position
// and either reflects at the edges or wraps around the screen.
module bounce_axis_step #(
  parameter int W     = 10,
  parameter int VEL_W = 4,
  parameter int MAX   = 624
) (
  input  logic [W-1:0]            pos,
  input  logic signed [VEL_W-1:0] vel,
  input  logic                    wrap,
  output logic [W-1:0]            next_pos,
  output logic signed [VEL_W-1:0] next_vel,
  output logic                    hit
);

  localparam int NW = W + 2;

  logic signed [NW-1:0] n;
  logic signed [NW-1:0] lim;
  logic signed [NW-1:0] span;

  assign lim  = NW'(MAX);
  assign span = NW'(MAX + 1);

  // Candidate position two bits wider than the register so under/overflow is visible.
  always_comb begin
    n        = $signed({2'b00, pos}) + $signed({{(NW - VEL_W){vel[VEL_W-1]}}, vel});
    next_pos = pos;
    next_vel = vel;
    hit      = 1'b0;
    if (vel != '0) begin
      if (wrap) begin
        if (n[NW-1])       next_pos = W'(n + span);
        else if (n > lim)  next_pos = W'(n - span);
        else               next_pos = W'(n);
      end else begin
        if (n[NW-1]) begin
          next_pos = '0;
          next_vel = -vel;
          hit      = 1'b1;
        end else if (n > lim) begin
          next_pos = W'(lim);
          next_vel = -vel;
          hit      = 1'b1;
        end else begin
          next_pos = W'(n);
        end
      end
    end
  end

endmodule

// File: rtl/bounce_motion_engine.sv
// Multi-object motion engine: holds position/velocity per sprite and, on each
// frame tick, sweeps the objects one per cycle through the axis steppers.
module bounce_motion_engine
  import bounce_pkg::*;
#(
  parameter int NUM_OBJ  = 4,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int VEL_W    = 4,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int OBJ_SIZE = 16,
  localparam int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     mode_wrap,
  input  logic                     freeze,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic [X_W-1:0]           cfg_x,
  input  logic [Y_W-1:0]           cfg_y,
  input  logic signed [VEL_W-1:0]  cfg_vx,
  input  logic signed [VEL_W-1:0]  cfg_vy,
  output logic [NUM_OBJ*X_W-1:0]   pos_x_o,
  output logic [NUM_OBJ*Y_W-1:0]   pos_y_o,
  output logic [NUM_OBJ-1:0]       bounce_x_o,
  output logic [NUM_OBJ-1:0]       bounce_y_o,
  output logic                     busy_o,
  output logic                     update_done_o,
  output logic                     overrun_o
);

  localparam int LIM_X = calc_max(SCREEN_W, OBJ_SIZE);
  localparam int LIM_Y = calc_max(SCREEN_H, OBJ_SIZE);

  state_t state_q, state_d;

  logic [X_W-1:0]          pos_x [NUM_OBJ];
  logic [Y_W-1:0]          pos_y [NUM_OBJ];
  logic signed [VEL_W-1:0] vel_x [NUM_OBJ];
  logic signed [VEL_W-1:0] vel_y [NUM_OBJ];

  logic [IDX_W-1:0]   idx;
  logic               pending, pending_d;
  logic               overrun, ovr_set;
  logic               wrap_q;
  logic               done_q;
  logic [NUM_OBJ-1:0] hit_acc_x, hit_acc_y;
  logic [NUM_OBJ-1:0] bounce_x_q, bounce_y_q;

  logic xfer, start, last_obj, tick_live, cfg_idx_ok;

  logic [X_W-1:0]          cfg_x_c;
  logic [Y_W-1:0]          cfg_y_c;
  logic signed [VEL_W-1:0] cfg_vx_c, cfg_vy_c;

  logic [X_W-1:0]          nx;
  logic [Y_W-1:0]          ny;
  logic signed [VEL_W-1:0] nvx, nvy;
  logic                    hx, hy;

  bounce_axis_step #(.W(X_W), .VEL_W(VEL_W), .MAX(LIM_X)) u_step_x (
    .pos      (pos_x[idx]),
    .vel      (vel_x[idx]),
    .wrap     (wrap_q),
    .next_pos (nx),
    .next_vel (nvx),
    .hit      (hx)
  );

  bounce_axis_step #(.W(Y_W), .VEL_W(VEL_W), .MAX(LIM_Y)) u_step_y (
    .pos      (pos_y[idx]),
    .vel      (vel_y[idx]),
    .wrap     (wrap_q),
    .next_pos (ny),
    .next_vel (nvy),
    .hit      (hy)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a config transfer always beats a sweep start.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    xfer      = 1'b0;
    start     = 1'b0;
    last_obj  = (int'(idx) == NUM_OBJ - 1);
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        xfer      = cfg_valid;
        if ((frame_tick || pending) && !freeze && !cfg_valid) begin
          start   = 1'b1;
          state_d = SWEEP;
        end
      end
      SWEEP:   if (last_obj) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tick bookkeeping: one tick may wait while busy; a second is dropped and flagged.
  always_comb begin
    tick_live = frame_tick && !freeze;
    ovr_set   = tick_live && pending;
    pending_d = pending;
    if (start)          pending_d = 1'b0;
    else if (tick_live) pending_d = 1'b1;
  end

  // Config write data: clamp position onto the screen and keep velocity negatable.
  always_comb begin
    cfg_idx_ok = (int'(cfg_idx) < NUM_OBJ);
    cfg_x_c    = (int'(cfg_x) > LIM_X) ? X_W'(LIM_X) : cfg_x;
    cfg_y_c    = (int'(cfg_y) > LIM_Y) ? Y_W'(LIM_Y) : cfg_y;
    cfg_vx_c   = VEL_W'(clamp_vel({{(16 - VEL_W){cfg_vx[VEL_W-1]}}, cfg_vx}, VEL_W));
    cfg_vy_c   = VEL_W'(clamp_vel({{(16 - VEL_W){cfg_vy[VEL_W-1]}}, cfg_vy}, VEL_W));
  end

  // Object registers, sweep index, edge-hit collection and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= VEL_W'(1);
        vel_y[i] <= VEL_W'(1);
      end
      idx        <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_acc_x  <= '0;
      hit_acc_y  <= '0;
      bounce_x_q <= '0;
      bounce_y_q <= '0;
    end else begin
      pending    <= pending_d;
      if (ovr_set) overrun <= 1'b1;
      done_q     <= (state_q == DONE);
      bounce_x_q <= (state_q == DONE) ? hit_acc_x : '0;
      bounce_y_q <= (state_q == DONE) ? hit_acc_y : '0;

      if (start) begin
        wrap_q    <= mode_wrap;
        idx       <= '0;
        hit_acc_x <= '0;
        hit_acc_y <= '0;
      end

      if (xfer && cfg_idx_ok) begin
        pos_x[cfg_idx] <= cfg_x_c;
        pos_y[cfg_idx] <= cfg_y_c;
        vel_x[cfg_idx] <= cfg_vx_c;
        vel_y[cfg_idx] <= cfg_vy_c;
      end

      if (state_q == SWEEP) begin
        pos_x[idx]     <= nx;
        pos_y[idx]     <= ny;
        vel_x[idx]     <= nvx;
        vel_y[idx]     <= nvy;
        hit_acc_x[idx] <= hx;
        hit_acc_y[idx] <= hy;
        idx            <= last_obj ? '0 : idx + 1'b1;
      end
    end
  end

  // Flatten the register arrays onto the packed output buses.
  always_comb begin
    pos_x_o = '0;
    pos_y_o = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      pos_x_o[i*X_W +: X_W] = pos_x[i];
      pos_y_o[i*Y_W +: Y_W] = pos_y[i];
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign update_done_o = done_q;
  assign bounce_x_o    = bounce_x_q;
  assign bounce_y_o    = bounce_y_q;
  assign overrun_o     = overrun;

endmodule
